// File: rtl/perceptron_layer_ctrl_if.sv
// Bus bundle for perceptron_layer_ctrl: config port, input vector stream,
// shared perceptron operand/result lines and result stream.
interface perceptron_layer_ctrl_if #(
   parameter int NEURONS = 4
);
   localparam int NIDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // The producer holds valid and its payload unchanged until that edge.
   // The consumer may drive ready at any time.
   logic              cfg_we;
   logic [NIDX_W-1:0] cfg_neuron;
   logic [3:0]        cfg_sel;
   logic [7:0]        cfg_data;
   logic              cfg_err;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic [7:0]        pe_in;
   logic [63:0]       pe_weights;
   logic [7:0]        pe_bias;
   logic [7:0]        pe_out;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;
   logic [NIDX_W-1:0] out_neuron;
   logic              out_last;
   logic              busy;
   logic [1:0]        dbg_state;

   modport master (
      output cfg_we, cfg_neuron, cfg_sel, cfg_data, in_valid, in_data,
             pe_out, out_ready,
      input  cfg_err, in_ready, pe_in, pe_weights, pe_bias, out_valid,
             out_data, out_neuron, out_last, busy, dbg_state
   );

   modport slave (
      input  cfg_we, cfg_neuron, cfg_sel, cfg_data, in_valid, in_data,
             pe_out, out_ready,
      output cfg_err, in_ready, pe_in, pe_weights, pe_bias, out_valid,
             out_data, out_neuron, out_last, busy, dbg_state
   );
endinterface

// File: rtl/perceptron_layer_ctrl.sv
// Time-multiplexes one perceptron across NEURONS virtual neurons of a layer.
// Define RELU_EN to clamp negative (bit7 set) results to zero on capture.
module perceptron_layer_ctrl #(
   parameter int NEURONS = 4,
   parameter int PE_LAT  = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   perceptron_layer_ctrl_if.slave bus
);
   localparam int NIDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
   localparam int DEPTH  = 2 ** NIDX_W;
   localparam logic [NIDX_W-1:0] LAST_IDX   = NIDX_W'(NEURONS - 1);
   localparam logic [NIDX_W:0]   NEURON_CNT = (NIDX_W + 1)'(NEURONS);
   localparam logic [2:0]        LAT_M1     = (PE_LAT > 0) ? 3'(PE_LAT - 1) : 3'd0;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

   state_t            r_state;
   logic [7:0]        r_w [DEPTH][8];
   logic [7:0]        r_b [DEPTH];
   logic [NIDX_W-1:0] r_idx;
   logic [2:0]        r_cnt;
   logic              r_in_ready;
   logic              r_busy;
   logic              r_cfg_err;
   logic              r_out_valid;
   logic [7:0]        r_out_data;
   logic [NIDX_W-1:0] r_out_neuron;
   logic              r_out_last;
   logic [7:0]        r_pe_in;
   logic [63:0]       r_pe_weights;
   logic [7:0]        r_pe_bias;

   logic              w_cfg_ok;
   logic              w_cfg_wr;
   logic              w_accept;
   logic              w_out_hs;
   logic [NIDX_W-1:0] w_idx_nxt;
   logic [63:0]       w_row0_w;
   logic [7:0]        w_row0_b;
   logic [63:0]       w_next_w;
   logic [7:0]        w_next_b;
   logic [7:0]        w_cap;

   always_comb begin
      w_cfg_ok  = (bus.cfg_sel <= 4'd8) && ({1'b0, bus.cfg_neuron} < NEURON_CNT);
      w_cfg_wr  = bus.cfg_we && w_cfg_ok && (r_state == S_IDLE);
      w_accept  = bus.in_valid && r_in_ready;
      w_out_hs  = r_out_valid && bus.out_ready;
      w_idx_nxt = r_idx + 1'b1;
      // Neuron 0 operands bypass a same-cycle write so it reaches this vector.
      for (int k = 0; k < 8; k++) begin
         w_row0_w[8*k +: 8] = (w_cfg_wr && bus.cfg_neuron == '0 && bus.cfg_sel == 4'(k))
                              ? bus.cfg_data : r_w[0][k];
         w_next_w[8*k +: 8] = r_w[w_idx_nxt][k];
      end
      w_row0_b = (w_cfg_wr && bus.cfg_neuron == '0 && bus.cfg_sel == 4'd8)
                 ? bus.cfg_data : r_b[0];
      w_next_b = r_b[w_idx_nxt];
`ifdef RELU_EN
      w_cap = bus.pe_out[7] ? 8'h00 : bus.pe_out;
`else
      w_cap = bus.pe_out;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_in_ready   <= 1'b1;
         r_busy       <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_neuron <= '0;
         r_out_last   <= 1'b0;
         r_pe_in      <= '0;
         r_pe_weights <= '0;
         r_pe_bias    <= '0;
         for (int n = 0; n < DEPTH; n++) begin
            r_b[n] <= '0;
            for (int k = 0; k < 8; k++) r_w[n][k] <= '0;
         end
      end else begin
         r_cfg_err <= bus.cfg_we && !w_cfg_wr;
         if (w_cfg_wr) begin
            if (bus.cfg_sel == 4'd8) r_b[bus.cfg_neuron] <= bus.cfg_data;
            else r_w[bus.cfg_neuron][bus.cfg_sel[2:0]] <= bus.cfg_data;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_idx        <= '0;
                  r_pe_in      <= bus.in_data;
                  r_pe_weights <= w_row0_w;
                  r_pe_bias    <= w_row0_b;
                  r_in_ready   <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (PE_LAT == 0) begin
                  r_out_data   <= w_cap;
                  r_out_neuron <= r_idx;
                  r_out_last   <= (r_idx == LAST_IDX);
                  r_out_valid  <= 1'b1;
                  r_state      <= S_OUT;
               end else begin
                  r_cnt   <= LAT_M1;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 3'd0) begin
                  r_out_data   <= w_cap;
                  r_out_neuron <= r_idx;
                  r_out_last   <= (r_idx == LAST_IDX);
                  r_out_valid  <= 1'b1;
                  r_state      <= S_OUT;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_OUT: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  if (r_idx == LAST_IDX) begin
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_idx        <= w_idx_nxt;
                     r_pe_weights <= w_next_w;
                     r_pe_bias    <= w_next_b;
                     r_state      <= S_ISSUE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cfg_err    = r_cfg_err;
   assign bus.in_ready   = r_in_ready;
   assign bus.pe_in      = r_pe_in;
   assign bus.pe_weights = r_pe_weights;
   assign bus.pe_bias    = r_pe_bias;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.out_neuron = r_out_neuron;
   assign bus.out_last   = r_out_last;
   assign bus.busy       = r_busy;
   assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_perceptron_layer_ctrl.sv
// Bench for perceptron_layer_ctrl: behavioural perceptron plus a layer-level
// reference model feeding an expected-result queue.
module tb_perceptron_layer_ctrl;
   localparam int NEURONS = 4;
   localparam int PE_LAT  = 1;
   localparam int NIDX_W  = (NEURONS > 1) ? $clog2(NEURONS) : 1;
   localparam int W       = 9 + NIDX_W;
   localparam int PIDX    = (PE_LAT == 0) ? 0 : PE_LAT - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   perceptron_layer_ctrl_if #(.NEURONS(NEURONS)) bus();

   perceptron_layer_ctrl #(.NEURONS(NEURONS), .PE_LAT(PE_LAT)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- perceptron with PE_LAT cycles of latency ----------------
   logic [7:0] pe_f;
   logic [7:0] pe_pipe [8];

   always_comb begin
      pe_f = bus.pe_bias;
      for (int k = 0; k < 8; k++)
         if (bus.pe_in[k]) pe_f = pe_f + bus.pe_weights[8*k +: 8];
   end

   always @(posedge clk) begin
      pe_pipe[0] <= pe_f;
      for (int i = 1; i < 8; i++) pe_pipe[i] <= pe_pipe[i-1];
   end

   assign bus.pe_out = (PE_LAT == 0) ? pe_f : pe_pipe[PIDX];

   // ---------------- reference model and scoreboard state ----------------
   logic [7:0] m_w [NEURONS][8];
   logic [7:0] m_b [NEURONS];
   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   function automatic logic [7:0] ref_result(input int n, input logic [7:0] vec);
      int s;
      logic [7:0] r;
      s = int'(m_b[n]);
      for (int k = 0; k < 8; k++)
         if (vec[k]) s += int'(m_w[n][k]);
      r = 8'(s % 256);
`ifdef RELU_EN
      if (r[7]) r = 8'h00;
`endif
      return r;
   endfunction

   task automatic model_clear();
      for (int n = 0; n < NEURONS; n++) begin
         m_b[n] = 8'h00;
         for (int k = 0; k < 8; k++) m_w[n][k] = 8'h00;
      end
   endtask

   task automatic push_expected(input logic [7:0] vec);
      for (int n = 0; n < NEURONS; n++)
         exp_q.push_back({1'(n == NEURONS - 1), NIDX_W'(n), ref_result(n, vec)});
   endtask

   // ---------------- driver tasks (start and end just after a negedge) ----------------
   task automatic cfg_write(input int n, input logic [3:0] sel, input logic [7:0] data);
      logic exp_err;
      exp_err = (sel > 4'd8) || (n >= NEURONS);
      bus.cfg_we     = 1'b1;
      bus.cfg_neuron = NIDX_W'(n);
      bus.cfg_sel    = sel;
      bus.cfg_data   = data;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      n_vec++;
      if (bus.cfg_err !== exp_err) begin
         n_err++;
         $display("FAIL cfg_err_pulse n=%0d sel=%0d: got %b expected %b", n, sel, bus.cfg_err, exp_err);
      end
      if (!exp_err) begin
         if (sel == 4'd8) m_b[n] = data;
         else m_w[n][sel[2:0]] = data;
      end
      @(negedge clk);
      n_vec++;
      if (bus.cfg_err !== 1'b0) begin
         n_err++;
         $display("FAIL cfg_err_clear n=%0d sel=%0d: got %b expected 0", n, sel, bus.cfg_err);
      end
   endtask

   task automatic send_vector(input logic [7:0] vec);
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL in_ready_idle: got %b expected 1", bus.in_ready);
      end
      push_expected(vec);
      bus.in_data  = vec;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
   endtask

   // Pops up to count results, with out_ready held low hold cycles per result.
   task automatic scoreboard(input bit check_lat, input int hold_idx, input int hold_n,
                             input int bp_max, input int count);
      logic [W-1:0] exp;
      logic [W-1:0] snap_out;
      logic [79:0]  snap_pe;
      int cycles;
      int hold;
      int nidx;
      for (int r = 0; r < count; r++) begin
         if (exp_q.size() == 0) break;
         exp = exp_q.pop_front();
         nidx = int'(exp[8 +: NIDX_W]);
         cycles = 0;
         while (bus.out_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
         end
         n_vec++;
         if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL out_valid_timeout neuron=%0d: got out_valid=%b after %0d cycles, expected 1",
                     nidx, bus.out_valid, cycles);
            exp_q.delete();
            return;
         end
         if (check_lat) begin
            n_vec++;
            if (cycles != PE_LAT + 1) begin
               n_err++;
               $display("FAIL result_latency neuron=%0d: got %0d cycles expected %0d", nidx, cycles, PE_LAT + 1);
            end
         end
         n_vec++;
         if ({bus.out_last, bus.out_neuron, bus.out_data} !== exp) begin
            n_err++;
            $display("FAIL result neuron=%0d: got last=%b neuron=%0d data=%h expected last=%b neuron=%0d data=%h",
                     nidx, bus.out_last, bus.out_neuron, bus.out_data, exp[W-1], exp[8 +: NIDX_W], exp[7:0]);
         end
         n_vec++;
         if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_active neuron=%0d: got %b expected 1", nidx, bus.busy);
         end
         hold = (nidx == hold_idx) ? hold_n : int'($urandom_range(0, bp_max));
         snap_out = {bus.out_last, bus.out_neuron, bus.out_data};
         snap_pe  = {bus.pe_in, bus.pe_weights, bus.pe_bias};
         repeat (hold) begin
            @(negedge clk);
            n_vec++;
            if (bus.out_valid !== 1'b1 || {bus.out_last, bus.out_neuron, bus.out_data} !== snap_out ||
                {bus.pe_in, bus.pe_weights, bus.pe_bias} !== snap_pe) begin
               n_err++;
               $display("FAIL hold_stable neuron=%0d: got valid=%b out=%h pe=%h expected valid=1 out=%h pe=%h",
                        nidx, bus.out_valid, {bus.out_last, bus.out_neuron, bus.out_data},
                        {bus.pe_in, bus.pe_weights, bus.pe_bias}, snap_out, snap_pe);
            end
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         n_vec++;
         if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_drop neuron=%0d: got out_valid=%b expected 0", nidx, bus.out_valid);
         end
      end
      if (exp_q.size() == 0) begin
         n_vec++;
         if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL end_of_vector: got in_ready=%b busy=%b expected in_ready=1 busy=0",
                     bus.in_ready, bus.busy);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cfg_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got in_ready=%b out_valid=%b busy=%b cfg_err=%b expected 1 0 0 0",
                  bus.in_ready, bus.out_valid, bus.busy, bus.cfg_err);
      end
      n_vec++;
      if (bus.out_data !== 8'h00 || bus.out_neuron !== '0 || bus.out_last !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out: got data=%h neuron=%0d last=%b expected 00 0 0",
                  bus.out_data, bus.out_neuron, bus.out_last);
      end
      n_vec++;
      if (bus.pe_in !== 8'h00 || bus.pe_weights !== 64'h0 || bus.pe_bias !== 8'h00) begin
         n_err++;
         $display("FAIL reset_pe: got in=%h w=%h b=%h expected all zero", bus.pe_in, bus.pe_weights, bus.pe_bias);
      end
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_basic();
      for (int k = 0; k < 8; k++) cfg_write(0, 4'(k), 8'h01);
      cfg_write(0, 4'd8, 8'h00);
      send_vector(8'hFF);
      scoreboard(1'b1, -1, 0, 0, NEURONS);
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 8; k++) cfg_write(1, 4'(k), 8'h40);
      cfg_write(1, 4'd8, 8'h10);
      send_vector(8'hFF);
      scoreboard(1'b1, -1, 0, 0, NEURONS);
      send_vector(8'h01);
      scoreboard(1'b1, -1, 0, 0, NEURONS);
   endtask

   task automatic test_backpressure();
      cfg_write(2, 4'd3, 8'h21);
      cfg_write(2, 4'd8, 8'h05);
      send_vector(8'($urandom) | 8'h08);
      scoreboard(1'b1, 2, 5, 0, NEURONS);
   endtask

   task automatic test_cfg_errors();
      cfg_write(0, 4'd9, 8'hEE);
      cfg_write(3, 4'd15, 8'hEE);
      cfg_write(3, 4'd8, 8'h33);
      send_vector(8'h5A);
      scoreboard(1'b1, -1, 0, 1, NEURONS);
   endtask

   task automatic test_cfg_busy();
      cfg_write(0, 4'd0, 8'h05);
      send_vector(8'h01);
      @(negedge clk);
      bus.cfg_we     = 1'b1;
      bus.cfg_neuron = '0;
      bus.cfg_sel    = 4'd0;
      bus.cfg_data   = 8'hAA;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      n_vec++;
      if (bus.cfg_err !== 1'b1) begin
         n_err++;
         $display("FAIL cfg_err_busy: got %b expected 1", bus.cfg_err);
      end
      @(negedge clk);
      n_vec++;
      if (bus.cfg_err !== 1'b0) begin
         n_err++;
         $display("FAIL cfg_err_busy_clear: got %b expected 0", bus.cfg_err);
      end
      scoreboard(1'b0, -1, 0, 0, 1);
      scoreboard(1'b1, -1, 0, 0, NEURONS - 1);
      send_vector(8'h01);
      scoreboard(1'b1, -1, 0, 0, NEURONS);
      // write and accept land on the same edge
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL in_ready_same_cycle: got %b expected 1", bus.in_ready);
      end
      bus.cfg_we     = 1'b1;
      bus.cfg_neuron = '0;
      bus.cfg_sel    = 4'd0;
      bus.cfg_data   = 8'h11;
      bus.in_data    = 8'h01;
      bus.in_valid   = 1'b1;
      m_w[0][0] = 8'h11;
      push_expected(8'h01);
      @(negedge clk);
      bus.cfg_we   = 1'b0;
      bus.in_valid = 1'b0;
      n_vec++;
      if (bus.cfg_err !== 1'b0) begin
         n_err++;
         $display("FAIL cfg_err_same_cycle: got %b expected 0", bus.cfg_err);
      end
      scoreboard(1'b1, -1, 0, 0, NEURONS);
   endtask

   task automatic test_relu();
      for (int k = 0; k < 8; k++) begin
         cfg_write(2, 4'(k), 8'h00);
         cfg_write(3, 4'(k), (k == 0) ? 8'h90 : 8'h00);
      end
      cfg_write(2, 4'd8, 8'h7F);
      cfg_write(3, 4'd8, 8'h00);
      send_vector(8'h01);
      scoreboard(1'b1, -1, 0, 0, NEURONS);
   endtask

   task automatic test_random();
      repeat (4) begin
         for (int n = 0; n < NEURONS; n++)
            for (int s = 0; s < 9; s++) cfg_write(n, 4'(s), 8'($urandom));
         repeat (3) begin
            send_vector(8'($urandom));
            scoreboard(1'b1, -1, 0, 2, NEURONS);
         end
      end
   endtask

   task automatic test_reset_mid();
      int cycles;
      for (int n = 0; n < NEURONS; n++) cfg_write(n, 4'd8, 8'($urandom_range(1, 255)));
      send_vector(8'hFF);
      scoreboard(1'b1, -1, 0, 0, 1);
      cycles = 0;
      while (bus.out_valid !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_neuron !== NIDX_W'(1)) begin
         n_err++;
         $display("FAIL reach_neuron1: got valid=%b neuron=%0d expected valid=1 neuron=1",
                  bus.out_valid, bus.out_neuron);
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: got out_valid=%b in_ready=%b busy=%b expected 0 1 0",
                  bus.out_valid, bus.in_ready, bus.busy);
      end
      rst_n = 1'b1;
      model_clear();
      exp_q.delete();
      @(negedge clk);
      send_vector(8'hFF);
      scoreboard(1'b1, -1, 0, 0, NEURONS);
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      bus.cfg_we     = 1'b0;
      bus.cfg_neuron = '0;
      bus.cfg_sel    = 4'd0;
      bus.cfg_data   = 8'h00;
      bus.in_valid   = 1'b0;
      bus.in_data    = 8'h00;
      bus.out_ready  = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_cfg_errors();
      test_cfg_busy();
      test_relu();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish by 300000 time units");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/perceptron_layer_ctrl.md
Name: perceptron_layer_ctrl

Overview:
Sequencer that time-multiplexes one shared perceptron datapath across NEURONS virtual neurons to form a single layer. Holds each neuron's 8 weights and bias in a local register file, loaded over a config port. Accepts an 8-bit binary input vector over valid/ready and drives operands to the perceptron one neuron at a time. Captures each 8-bit result and streams it out with neuron index and a last flag.

Parameters:
NEURONS, 4, number of virtual neurons in the layer (1..16)
PE_LAT, 1, cycles between operands becoming stable and pe_out being valid (0..7)
NIDX_W, max(1,$clog2(NEURONS)), derived localparam; width of neuron index

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  config write strobe
cfg_neuron  in  NIDX_W  target neuron for write
cfg_sel  in  4  0..7 = weight k, 8 = bias, 9..15 reserved
cfg_data  in  8  write data
cfg_err  out  1  one-cycle pulse: write rejected
in_valid  in  1  input vector valid
in_ready  out  1  controller can accept a vector
in_data  in  8  binary input vector, bit k gates weight k
pe_in  out  8  to perceptron "in"
pe_weights  out  64  weight k on [8k+7:8k]
pe_bias  out  8  to perceptron bias
pe_out  in  8  perceptron result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  8  captured result
out_neuron  out  NIDX_W  index of neuron producing out_data
out_last  out  1  high with the result of neuron NEURONS-1
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at edge): state IDLE; all weight/bias registers 0; input latch 0; neuron index 0; wait counter 0. Outputs in_ready=1, out_valid=0, out_data=0, out_neuron=0, out_last=0, cfg_err=0, busy=0, pe_in/pe_weights/pe_bias=0. Reset mid-operation aborts the vector and discards any pending result.
- FSM IDLE -> ISSUE -> (WAIT if PE_LAT>0) -> OUT -> ISSUE (next neuron) or IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, idx=0, go ISSUE.
- ISSUE (1 cycle): drive pe_in=latched vector, pe_weights/pe_bias from reg file[idx]. Operands held stable through ISSUE and WAIT. If PE_LAT=0, capture pe_out into out_data at end of ISSUE and go OUT; else load counter and go WAIT.
- WAIT: lasts exactly PE_LAT cycles. Capture pe_out at the last WAIT edge, then go OUT.
- OUT: out_valid=1, out_data/out_neuron/out_last stable until out_ready. On handshake: if idx==NEURONS-1 go IDLE, else idx+1 and go ISSUE.
- Timing: first out_valid is asserted PE_LAT+1 cycles after the input-accept edge. Each further neuron adds PE_LAT+1 cycles plus backpressure.
- Config writes:
  - Accepted only in IDLE.
  - cfg_we outside IDLE, cfg_sel>=9, or cfg_neuron>=NEURONS: write ignored, cfg_err pulses 1 cycle.
  - A write and an input accept in the same IDLE cycle are both performed. The write is visible to the vector just accepted, because ISSUE reads the reg file next cycle.
- Arithmetic belongs to the perceptron: 8-bit unsigned, wraps mod 256. The controller never modifies the result except as described under Optional Feature.
- pe_* outputs hold their last values in OUT and IDLE. No requirement on their value there beyond stability.

Optional Feature:
RELU_EN. When defined, the captured result is treated as signed 8-bit; values with bit7=1 are stored as 8'h00, others unchanged. When undefined, pe_out is captured unmodified. Latency is identical in both builds.

Test Plan:
- Reset, then NEURONS=4, PE_LAT=1: neuron0 weights all 8'h01, bias 0; in_data=8'hFF -> neuron0 out_data=8'h08, out_neuron=0, first out_valid 2 cycles after accept; 4 results total, out_last only on neuron 3.
- Wrap: neuron1 weights all 8'h40, bias 8'h10, in_data=8'hFF -> out_data=8'h10. Same weights, in_data=8'h01 -> out_data=8'h50.
- Backpressure: hold out_ready=0 for 5 cycles on neuron2 -> out_valid, out_data and out_neuron stable; pe_* stable; no advance to neuron 3 until the handshake.
- Config while busy: cfg_we during WAIT for neuron0 weight0 -> cfg_err=1 for 1 cycle, next vector uses old weight. Write in same cycle as input accept -> new weight used.
- Reset mid-vector: rst_n low during OUT of neuron1 -> next cycle out_valid=0, in_ready=1, reg file all zero; a new vector with in_data=8'hFF yields out_data=8'h00 for every neuron.
- RELU_EN build: neuron weights giving result 8'h90 -> out_data=8'h00; result 8'h7F passes unchanged. Non-RELU build: 8'h90 passes unchanged.
